ball_multi_mv: RTL and testbench
================================

BALL_MULTI_MV -- requirements
Module: ball_multi_mv

Interface
REQ-001 Parameter NUM_BALLS, default 4, is the number of balls, legal range 1..8; ball 0 is player-controlled and balls 1..NUM_BALLS-1 are autonomous.
REQ-002 Parameter BALL_SIZE, default 16, is the square ball edge in pixels.
REQ-003 Parameter SPEED, default 2, is the pixels moved per frame per axis, legal range 1..15.
REQ-004 Parameter H_ACTIVE, default 640, is the visible width in pixels.
REQ-005 Parameter V_ACTIVE, default 480, is the visible height in pixels.
REQ-006 The module SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-007 i_clk  in  1  pixel clock; all state on rising edge.
REQ-008 i_rst_n  in  1  async active-low reset.
REQ-009 i_vsync  in  1  vertical sync from sync generator.
REQ-010 i_visible  in  1  current pixel is in the active area.
REQ-011 i_hpos, i_vpos  in  10 each  current pixel coordinates.
REQ-012 i_up, i_down, i_left, i_right  in  1 each  player buttons, synchronous, active-high.
REQ-013 o_rgb  out  3  pixel colour, bit0=R, bit1=G, bit2=B.
REQ-014 o_hit  out  1  player/ball collision flag (see Configuration).

Function
REQ-015 Per-ball x, y SHALL be 10-bit unsigned top-left corners; autonomous balls also hold signed velocities vx, vy of +/-SPEED.
REQ-016 Rising edge of i_vsync SHALL be detected via a registered copy; the edge starts the update FSM.
REQ-017 FSM states: IDLE and UPDATE. IDLE->UPDATE on vsync edge with idx=0; UPDATE processes ball idx in one cycle, then idx+1; idx==NUM_BALLS-1 -> IDLE. Update completes in exactly NUM_BALLS cycles.
REQ-018 Vsync edges arriving while in UPDATE SHALL be ignored.
REQ-019 Ball 0: i_up subtracts SPEED from y, i_down adds it; i_left/i_right do the same for x. Opposing buttons held together cancel. Results clamp to [0, V_ACTIVE-BALL_SIZE] and [0, H_ACTIVE-BALL_SIZE]; no wrap.
REQ-020 Autonomous ball: next=pos+v per axis. If next<0, pos=0 and v negated; if next>limit, pos=limit and v negated; otherwise pos=next. Overflow SHALL be evaluated in 11-bit signed arithmetic.
REQ-021 Ball i covers a pixel when 0<=i_hpos-x<BALL_SIZE and 0<=i_vpos-y<BALL_SIZE.
REQ-022 o_rgb SHALL be registered with 1-cycle latency: 0 when i_visible is 0; otherwise the colour of the lowest-index covering ball; 0 if no ball covers the pixel.
REQ-023 Colours: ball 0 = 3'b111; ball i>0 = ((i-1) mod 6)+1.

Reset
REQ-024 On i_rst_n low, and asynchronously: FSM=IDLE, idx=0, vsync copy=0, o_rgb=0, o_hit=0, collision flags=0.
REQ-025 Reset SHALL set ball i to x=32+64*i, y=32+32*i; vx=+SPEED for even i, -SPEED for odd i; vy=+SPEED.
REQ-026 Reset mid-UPDATE SHALL abandon the update; partially updated balls return to reset values.

Configuration
REQ-027 With BALL_MULTI_COLLIDE_EN defined: on a visible pixel covered by ball 0 and ball k>0, flag[k] is set and o_hit goes high on the next cycle.
REQ-028 While BALL_MULTI_COLLIDE_EN is defined, the update of ball k with flag[k] set SHALL negate vx and vy before moving and clear flag[k]; o_hit clears on the cycle the FSM returns to IDLE.
REQ-029 Without BALL_MULTI_COLLIDE_EN, flags are not built and o_hit is constant 0.

Structure
REQ-030 Package ball_pkg SHALL hold the coordinate width (10), the colour constants, the palette function, the initial-position constants, and the FSM state enum.
REQ-031 Sub-module ball_axis_step SHALL implement one axis step (pos, vel, limit -> pos, vel); it is instantiated twice.

Verification
REQ-032 Reset release, then the first frame with no buttons -> ball 1 at (96,64) moves to (94,66); ball 0 stays at (32,32).
REQ-033 i_right held for 3 vsync edges with ball 0 at x=620, SPEED=2 -> x = 622, 624, 624 (clamped).
REQ-034 Ball 1 at x=1, vx=-2, vsync edge -> x=0, vx=+2; next frame -> x=2.
REQ-035 Pixel (32,32) visible at reset -> o_rgb=3'b111 one cycle later; same pixel with i_visible=0 -> o_rgb=0.
REQ-036 With BALL_MULTI_COLLIDE_EN, ball 0 and ball 2 overlapping -> o_hit=1, and ball 2 velocity is negated at the next update; without the macro -> o_hit stays 0.
REQ-037 Second vsync edge injected during UPDATE with NUM_BALLS=8 -> exactly one update per ball.

Source files
------------

// File: rtl/ball_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | ball_pkg : shared widths, palette, reset placement and FSM encoding.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
package ball_pkg;

    localparam int COORD_W = 10;
    localparam int VEL_W   = 5;
    localparam int IDX_W   = 3;

    localparam logic [2:0] COLOR_BLACK  = 3'b000;
    localparam logic [2:0] COLOR_PLAYER = 3'b111;

    localparam int INIT_X_BASE = 32;
    localparam int INIT_X_STEP = 64;
    localparam int INIT_Y_BASE = 32;
    localparam int INIT_Y_STEP = 32;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_e;

    // Autonomous balls cycle through the six non-black, non-white colours.
    function automatic logic [2:0] ball_color(input int idx);
        if (idx == 0) begin
            return COLOR_PLAYER;
        end
        return 3'(((idx - 1) % 6) + 1);
    endfunction

    function automatic logic [COORD_W-1:0] init_x(input int idx);
        return COORD_W'(INIT_X_BASE + INIT_X_STEP * idx);
    endfunction

    function automatic logic [COORD_W-1:0] init_y(input int idx);
        return COORD_W'(INIT_Y_BASE + INIT_Y_STEP * idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ball_axis_step.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | ball_axis_step : one-axis move with bounce/clamp at 0 and limit.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
module ball_axis_step
    import ball_pkg::*;
(
    input  logic [COORD_W-1:0]      i_pos,
    input  logic signed [VEL_W-1:0] i_vel,
    input  logic [COORD_W-1:0]      i_limit,
    output logic [COORD_W-1:0]      o_pos,
    output logic signed [VEL_W-1:0] o_vel
);

    logic signed [COORD_W:0] w_vel_ext;
    logic signed [COORD_W:0] w_next;
    logic signed [COORD_W:0] w_limit;

    assign w_vel_ext = {{(COORD_W + 1 - VEL_W){i_vel[VEL_W-1]}}, i_vel};
    assign w_next    = $signed({1'b0, i_pos}) + w_vel_ext;
    assign w_limit   = $signed({1'b0, i_limit});

    always_comb begin
        o_pos = w_next[COORD_W-1:0];
        o_vel = i_vel;
        if (w_next[COORD_W]) begin
            o_pos = '0;
            o_vel = -i_vel;
        end else if (w_next > w_limit) begin
            o_pos = i_limit;
            o_vel = -i_vel;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ball_multi_mv.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | ball_multi_mv : one player ball plus bouncing balls, per-frame update FSM
// | and pixel renderer. Optional collision flags under BALL_MULTI_COLLIDE_EN.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
module ball_multi_mv
    import ball_pkg::*;
#(
    parameter int NUM_BALLS = 4,
    parameter int BALL_SIZE = 16,
    parameter int SPEED     = 2,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_vsync,
    input  logic               i_visible,
    input  logic [COORD_W-1:0] i_hpos,
    input  logic [COORD_W-1:0] i_vpos,
    input  logic               i_up,
    input  logic               i_down,
    input  logic               i_left,
    input  logic               i_right,
    output logic [2:0]         o_rgb,
    output logic               o_hit
);

    localparam int                      CW1     = COORD_W + 1;
    localparam logic [COORD_W-1:0]      X_LIMIT = COORD_W'(H_ACTIVE - BALL_SIZE);
    localparam logic [COORD_W-1:0]      Y_LIMIT = COORD_W'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [VEL_W-1:0] VEL_POS = VEL_W'(SPEED);
    localparam logic signed [VEL_W-1:0] VEL_NEG = VEL_W'(-SPEED);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_BALLS - 1);
    localparam logic signed [COORD_W:0] SIZE_S  = CW1'(BALL_SIZE);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               vsync_q;
    logic               w_vsync_rise;
    logic               w_upd_en;
    logic               w_upd_last;

    logic [COORD_W-1:0]      x_q  [NUM_BALLS];
    logic [COORD_W-1:0]      y_q  [NUM_BALLS];
    logic signed [VEL_W-1:0] vx_q [NUM_BALLS];
    logic signed [VEL_W-1:0] vy_q [NUM_BALLS];

    logic [COORD_W-1:0]      w_cur_x, w_cur_y, w_x_new, w_y_new;
    logic signed [VEL_W-1:0] w_cur_vx, w_cur_vy, w_btn_vx, w_btn_vy;
    logic signed [VEL_W-1:0] w_step_vx, w_step_vy, w_vx_new, w_vy_new;
    logic                    w_is_player;
    logic                    w_cur_flag;

    logic [NUM_BALLS-1:0]    w_cover;
    logic [2:0]              w_color;
    logic [2:0]              rgb_q;

    assign w_vsync_rise = i_vsync & ~vsync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vsync_q <= i_vsync;
        end
    end

    // Edges seen while already updating fall through the UPDATE branch unused.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (w_vsync_rise) begin
                    state_d = ST_UPDATE;
                    idx_d   = '0;
                end
            end
            ST_UPDATE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        w_upd_en   = 1'b0;
        w_upd_last = 1'b0;
        if (state_q == ST_UPDATE) begin
            w_upd_en   = 1'b1;
            w_upd_last = (idx_q == LAST_IDX);
        end
    end

    always_comb begin
        w_cur_x  = '0;
        w_cur_y  = '0;
        w_cur_vx = '0;
        w_cur_vy = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_cur_x  = x_q[i];
                w_cur_y  = y_q[i];
                w_cur_vx = vx_q[i];
                w_cur_vy = vy_q[i];
            end
        end
    end

    assign w_is_player = (idx_q == '0);

    // The player reuses the bounce stepper: its clamp is the same saturation,
    // and the returned velocity is simply discarded.
    always_comb begin
        w_btn_vx = '0;
        w_btn_vy = '0;
        if (i_right && !i_left) begin
            w_btn_vx = VEL_POS;
        end else if (i_left && !i_right) begin
            w_btn_vx = VEL_NEG;
        end
        if (i_down && !i_up) begin
            w_btn_vy = VEL_POS;
        end else if (i_up && !i_down) begin
            w_btn_vy = VEL_NEG;
        end
        if (w_is_player) begin
            w_step_vx = w_btn_vx;
            w_step_vy = w_btn_vy;
        end else if (w_cur_flag) begin
            w_step_vx = -w_cur_vx;
            w_step_vy = -w_cur_vy;
        end else begin
            w_step_vx = w_cur_vx;
            w_step_vy = w_cur_vy;
        end
    end

    ball_axis_step u_step_x (
        .i_pos   (w_cur_x),
        .i_vel   (w_step_vx),
        .i_limit (X_LIMIT),
        .o_pos   (w_x_new),
        .o_vel   (w_vx_new)
    );

    ball_axis_step u_step_y (
        .i_pos   (w_cur_y),
        .i_vel   (w_step_vy),
        .i_limit (Y_LIMIT),
        .o_pos   (w_y_new),
        .o_vel   (w_vy_new)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                x_q[i]  <= init_x(i);
                y_q[i]  <= init_y(i);
                vx_q[i] <= (i % 2 == 0) ? VEL_POS : VEL_NEG;
                vy_q[i] <= VEL_POS;
            end
        end else if (w_upd_en) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    x_q[i] <= w_x_new;
                    y_q[i] <= w_y_new;
                    if (i != 0) begin
                        vx_q[i] <= w_vx_new;
                        vy_q[i] <= w_vy_new;
                    end
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_BALLS; g++) begin : g_cover
            logic signed [COORD_W:0] w_dx;
            logic signed [COORD_W:0] w_dy;
            assign w_dx = $signed({1'b0, i_hpos}) - $signed({1'b0, x_q[g]});
            assign w_dy = $signed({1'b0, i_vpos}) - $signed({1'b0, y_q[g]});
            assign w_cover[g] = !w_dx[COORD_W] && (w_dx < SIZE_S) &&
                                !w_dy[COORD_W] && (w_dy < SIZE_S);
        end
    endgenerate

    // Walk downwards so the lowest-index covering ball wins.
    always_comb begin
        w_color = COLOR_BLACK;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (w_cover[i]) begin
                w_color = ball_color(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rgb_q <= COLOR_BLACK;
        end else begin
            rgb_q <= i_visible ? w_color : COLOR_BLACK;
        end
    end

    assign o_rgb = rgb_q;

`ifdef BALL_MULTI_COLLIDE_EN
    localparam logic [NUM_BALLS-1:0] PLAYER_BIT = NUM_BALLS'(1);

    logic [NUM_BALLS-1:0] flag_q, flag_d;
    logic [NUM_BALLS-1:0] w_collide;
    logic                 hit_q, hit_d;

    assign w_collide = (i_visible && w_cover[0]) ? (w_cover & ~PLAYER_BIT) : '0;

    always_comb begin
        w_cur_flag = 1'b0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_cur_flag = flag_q[i];
            end
        end
    end

    // A collision on the same cycle as the consuming update is kept for next frame.
    always_comb begin
        flag_d = flag_q;
        if (w_upd_en) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    flag_d[i] = 1'b0;
                end
            end
        end
        flag_d = flag_d | w_collide;
        hit_d  = hit_q;
        if (w_upd_last) begin
            hit_d = 1'b0;
        end
        if (|w_collide) begin
            hit_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flag_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            hit_q  <= hit_d;
        end
    end

    assign o_hit = hit_q;
`else
    assign w_cur_flag = 1'b0;
    assign o_hit      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ball_multi_mv.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_ball_multi_mv : scoreboard bench for ball_multi_mv (8 balls).
// | Revision : 1.0
// +-----------------------------------------------------------------------------
module tb_ball_multi_mv;

    localparam int NB = 8;
    localparam int BS = 16;
    localparam int SP = 2;
    localparam int HA = 640;
    localparam int VA = 480;
    localparam int XL = HA - BS;
    localparam int YL = VA - BS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0;
    logic       visible = 1'b0;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [2:0] rgb;
    logic       hit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ball_multi_mv #(
        .NUM_BALLS (NB),
        .BALL_SIZE (BS),
        .SPEED     (SP),
        .H_ACTIVE  (HA),
        .V_ACTIVE  (VA)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_vsync   (vsync),
        .i_visible (visible),
        .i_hpos    (hpos),
        .i_vpos    (vpos),
        .i_up      (up),
        .i_down    (down),
        .i_left    (left),
        .i_right   (right),
        .o_rgb     (rgb),
        .o_hit     (hit)
    );

    // Reference model of the ball field
    int mx [NB];
    int my [NB];
    int mvx[NB];
    int mvy[NB];
    bit mflag[NB];
    bit mhit;

    typedef struct {
        int         id;
        logic [2:0] rgb;
        logic       hit;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   probe_id = 0;

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (rgb !== mon_e.rgb) begin
                errors++;
                $display("FAIL rgb probe %0d: got %0d expected %0d", mon_e.id, rgb, mon_e.rgb);
            end
            checks++;
            if (hit !== mon_e.hit) begin
                errors++;
                $display("FAIL hit probe %0d: got %0b expected %0b", mon_e.id, hit, mon_e.hit);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            mx[i]    = 32 + 64 * i;
            my[i]    = 32 + 32 * i;
            mvx[i]   = (i % 2 == 0) ? SP : -SP;
            mvy[i]   = SP;
            mflag[i] = 1'b0;
        end
        mhit = 1'b0;
    endtask

    task automatic model_frame(input bit u, input bit d, input bit l, input bit r);
        int n;
        n = mx[0] + ((r && !l) ? SP : 0) - ((l && !r) ? SP : 0);
        mx[0] = (n < 0) ? 0 : ((n > XL) ? XL : n);
        n = my[0] + ((d && !u) ? SP : 0) - ((u && !d) ? SP : 0);
        my[0] = (n < 0) ? 0 : ((n > YL) ? YL : n);
        for (int k = 1; k < NB; k++) begin
            if (mflag[k]) begin
                mvx[k]   = -mvx[k];
                mvy[k]   = -mvy[k];
                mflag[k] = 1'b0;
            end
            n = mx[k] + mvx[k];
            if (n < 0) begin mx[k] = 0; mvx[k] = -mvx[k]; end
            else if (n > XL) begin mx[k] = XL; mvx[k] = -mvx[k]; end
            else mx[k] = n;
            n = my[k] + mvy[k];
            if (n < 0) begin my[k] = 0; mvy[k] = -mvy[k]; end
            else if (n > YL) begin my[k] = YL; mvy[k] = -mvy[k]; end
            else my[k] = n;
        end
        mhit = 1'b0;
    endtask

    function automatic bit model_cov(input int i, input int h, input int v);
        return (h >= mx[i]) && (h < mx[i] + BS) && (v >= my[i]) && (v < my[i] + BS);
    endfunction

    function automatic logic [2:0] model_rgb(input int h, input int v);
        for (int i = 0; i < NB; i++) begin
            if (model_cov(i, h, v)) return (i == 0) ? 3'b111 : 3'(((i - 1) % 6) + 1);
        end
        return 3'b000;
    endfunction

    task automatic probe(input int h, input int v, input bit vis);
        exp_t e;
        @(negedge clk);
        hpos    = 10'(h);
        vpos    = 10'(v);
        visible = vis;
        e.id    = probe_id;
        probe_id++;
        e.rgb   = vis ? model_rgb(h, v) : 3'b000;
`ifdef BALL_MULTI_COLLIDE_EN
        if (vis && model_cov(0, h, v)) begin
            for (int k = 1; k < NB; k++) begin
                if (model_cov(k, h, v)) begin
                    mflag[k] = 1'b1;
                    mhit     = 1'b1;
                end
            end
        end
`endif
        e.hit = mhit;
        sb.push_back(e);
        @(negedge clk);
        visible = 1'b0;
    endtask

    task automatic frame(input bit u, input bit d, input bit l, input bit r);
        @(negedge clk);
        up = u; down = d; left = l; right = r;
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (12) @(negedge clk);
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        model_frame(u, d, l, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        visible = 1'b1;
        hpos    = 10'd32;
        vpos    = 10'd32;
        repeat (3) @(negedge clk);
        checks++;
        if (rgb !== 3'b000) begin
            errors++;
            $display("FAIL reset_rgb: got %0d expected 0", rgb);
        end
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_hit: got %0b expected 0", hit);
        end
        visible = 1'b0;
        rst_n   = 1'b1;
        model_reset();
        probe(32, 32, 1);
        probe(47, 47, 1);
        probe(48, 32, 1);
        probe(31, 32, 1);
        probe(96, 64, 1);
        probe(160, 96, 1);
        probe(480, 256, 1);
        probe(32, 32, 0);
    endtask

    task automatic test_first_frame();
        frame(0, 0, 0, 0);
        probe(94, 66, 1);
        probe(93, 66, 1);
        probe(94, 65, 1);
        probe(32, 32, 1);
        probe(31, 32, 1);
        probe(478, 258, 1);
        probe(477, 258, 1);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (14) @(negedge clk);
        model_frame(0, 0, 0, 0);
        probe(mx[1], my[1], 1);
        probe(mx[1] - 1, my[1], 1);
        probe(mx[7], my[7], 1);
        probe(mx[7] - 1, my[7], 1);
    endtask

    task automatic test_reset_mid_update();
        @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        probe(96, 64, 1);
        probe(95, 64, 1);
        probe(160, 96, 1);
        probe(32, 32, 1);
    endtask

    task automatic test_bounce();
        int n = 0;
        while (mx[1] > 0 && n < 100) begin
            frame(0, 0, 0, 0);
            n++;
        end
        probe(mx[1], my[1], 1);
        probe(mx[1] + BS - 1, my[1], 1);
        probe(mx[1] + BS, my[1], 1);
        frame(0, 0, 0, 0);
        probe(1, my[1], 1);
        probe(mx[1], my[1], 1);
        probe(mx[1] + BS - 1, my[1] + BS - 1, 1);
    endtask

    task automatic test_player_clamp();
        int n = 0;
        do_reset();
        while (mx[0] < 620 && n < 400) begin
            frame(0, 0, 0, 1);
            n++;
        end
        for (int f = 0; f < 3; f++) begin
            frame(0, 0, 0, 1);
            probe(mx[0], my[0], 1);
            probe(mx[0] - 1, my[0], 1);
        end
        probe(HA - 1, my[0], 1);
        frame(0, 0, 1, 1);
        probe(mx[0], my[0], 1);
        probe(mx[0] - 1, my[0], 1);
        for (int f = 0; f < 20; f++) frame(1, 0, 0, 0);
        probe(mx[0], 0, 1);
        probe(mx[0], BS, 1);
        for (int f = 0; f < 3; f++) frame(0, 1, 1, 0);
        probe(mx[0], my[0], 1);
        probe(mx[0] - 1, my[0], 1);
        probe(mx[0], my[0] - 1, 1);
    endtask

    task automatic test_collision();
        int  n = 0;
        bit  met = 1'b0;
        int  px, py;
        do_reset();
        while (!met && n < 800) begin
            frame(my[0] > my[2], my[0] < my[2], mx[0] > mx[2], mx[0] < mx[2]);
            met = (mx[0] - mx[2] < BS) && (mx[2] - mx[0] < BS) &&
                  (my[0] - my[2] < BS) && (my[2] - my[0] < BS);
            n++;
        end
        checks++;
        if (!met) begin
            errors++;
            $display("FAIL collide_setup: got no overlap expected overlap within 800 frames");
        end
        px = (mx[0] > mx[2]) ? mx[0] : mx[2];
        py = (my[0] > my[2]) ? my[0] : my[2];
        probe(px, py, 1);
        probe(px, py, 0);
        frame(0, 0, 0, 0);
        probe(mx[2], my[2], 0);
        probe(mx[2] + BS - 1, my[2] + BS - 1, 1);
        probe(mx[2] - 1, my[2], 1);
        frame(0, 0, 0, 0);
        probe(mx[2], my[2] + BS - 1, 1);
        probe(mx[2] + BS, my[2], 1);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_reset_mid_update();
        test_bounce();
        test_player_clamp();
        test_collision();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
